tlb_op_ctrl: RTL and testbench
==============================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 2, number of TLB entries.
REQ-002 SHALL have parameter IDXW, default 1, index width (2**IDXW = TLBNUM).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  in  1  reset; synchronous, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_op in 3 (0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal), req_index in IDXW, req_asid in 10, req_vppn in 19, req_odd in 1, req_inv_op in 5, req_wentry in 89.
REQ-006 SHALL use 89-bit entry layout: [88:70] vppn, [69:60] asid, [59] g, [58:53] ps, [52] e, [51:26] page0, [25:0] page1; page = {v[25], d[24], mat[23:22], plv[21:20], ppn[19:0]} relative.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_op out 3, rsp_found out 1, rsp_index out IDXW, rsp_rentry out 89.
REQ-008 SHALL have TLB-side ports tlb_s1_fetch out 1, tlb_s1_vppn out 19, tlb_s1_odd_page out 1, tlb_s1_asid out 10, tlb_s1_found in 1, tlb_s1_index in IDXW.
REQ-009 SHALL have ports tlb_we out 1, tlb_w_index out IDXW, tlb_w_entry out 89, tlb_r_index out IDXW, tlb_r_entry in 89.
REQ-010 SHALL have ports tlb_inv_en out 1, tlb_inv_op out 5, tlb_inv_asid out 10, tlb_inv_vpn out 19, busy out 1.

Function
REQ-011 SHALL implement states IDLE, SFETCH, SWAIT, READ, WRITE, INV, RESP.
REQ-012 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready; latch all req_* fields.
REQ-013 SHALL transition on accept: SRCH->SFETCH, RD->READ, WR/FILL->WRITE, INV->INV, illegal op->RESP.
REQ-014 SHALL in SFETCH drive tlb_s1_fetch=1 with latched vppn/odd/asid for exactly one cycle, then SWAIT.
REQ-015 SHALL in SWAIT capture tlb_s1_found/tlb_s1_index into rsp_found/rsp_index, then RESP.
REQ-016 SHALL in READ drive tlb_r_index=latched index, capture tlb_r_entry into rsp_rentry, set rsp_found=1, rsp_index=index, then RESP.
REQ-017 SHALL in WRITE pulse tlb_we=1 for one cycle with tlb_w_entry=latched wentry; tlb_w_index=req_index for WR, latched fill counter for FILL; rsp_index=index used; then RESP.
REQ-018 SHALL keep a fill counter, free-running +1 per cycle, wrapping TLBNUM-1->0; sampled at accept of FILL.
REQ-019 SHALL in INV pulse tlb_inv_en=1 for one cycle with latched inv_op/asid/vppn only if inv_op<=6; inv_op>=7 SHALL produce no inv_en pulse; then RESP.
REQ-020 SHALL in RESP hold rsp_valid=1 and all rsp_* stable until rsp_ready; on rsp_valid && rsp_ready go IDLE.
REQ-021 SHALL report illegal op with rsp_found=0, rsp_index=0, rsp_rentry=0, no TLB strobe.
REQ-022 SHALL set rsp_found=0, rsp_rentry=0 for WR/FILL/INV responses; rsp_op = latched op always.
REQ-023 SHALL assert busy whenever state != IDLE.
REQ-024 SHALL hold tlb_s1_fetch, tlb_we, tlb_inv_en at 0 outside their states; never more than one strobe per cycle.
REQ-025 SHALL meet latency from accept cycle T: WR/FILL/INV strobe T+1, rsp_valid T+2; RD rsp_valid T+2; SRCH fetch T+1, rsp_valid T+3; illegal rsp_valid T+1.

Reset
REQ-026 SHALL on resetn=0 at a clock edge enter IDLE, clear fill counter and all rsp_* to 0, deassert all strobes and rsp_valid.
REQ-027 SHALL drop any in-flight op on reset mid-operation; no strobe or response follows.

Verification
REQ-028 SRCH vppn=0x12345, asid=0x05, TLB model holding match at index 1 -> tlb_s1_fetch at T+1, rsp_valid T+3, found=1, index=1.
REQ-029 WR index=1, wentry=0x1_2345_6789_ABCD_EF01_2345_67 -> single tlb_we at T+1, w_index=1, entry bit-exact; then RD index=1 returns same entry.
REQ-030 Two FILLs accepted 3 cycles apart with TLBNUM=2 -> w_index differs per counter value; counter wraps 1->0.
REQ-031 INV inv_op=4 asid=0x3 -> one inv_en pulse; inv_op=9 -> no pulse, rsp_valid still at T+2.
REQ-032 rsp_ready held low 5 cycles -> rsp_valid and rsp_* stable, req_ready=0, busy=1 throughout.
REQ-033 resetn low during SFETCH -> next cycle IDLE, fetch=0, no rsp_valid; illegal op 6 -> rsp_valid at T+1, found=0.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: accepts one TLB maintenance request at a time (search, read,
// write, fill, invalidate). It drives the matching TLB strobe and then holds
// a response until the requester takes it.
module tlb_op_ctrl #(
  parameter int TLBNUM = 2,
  parameter int IDXW   = 1
) (
  input  logic            clk,
  input  logic            resetn,
  // request channel
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [IDXW-1:0] req_index,
  input  logic [9:0]      req_asid,
  input  logic [18:0]     req_vppn,
  input  logic            req_odd,
  input  logic [4:0]      req_inv_op,
  input  logic [88:0]     req_wentry,
  // response channel
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2:0]      rsp_op,
  output logic            rsp_found,
  output logic [IDXW-1:0] rsp_index,
  output logic [88:0]     rsp_rentry,
  // TLB search port
  output logic            tlb_s1_fetch,
  output logic [18:0]     tlb_s1_vppn,
  output logic            tlb_s1_odd_page,
  output logic [9:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  // TLB write / read ports
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [88:0]     tlb_w_entry,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [88:0]     tlb_r_entry,
  // TLB invalidate port
  output logic            tlb_inv_en,
  output logic [4:0]      tlb_inv_op,
  output logic [9:0]      tlb_inv_asid,
  output logic [18:0]     tlb_inv_vpn,
  output logic            busy
);

  localparam logic [2:0]      OP_SRCH    = 3'd0;
  localparam logic [2:0]      OP_RD      = 3'd1;
  localparam logic [2:0]      OP_WR      = 3'd2;
  localparam logic [2:0]      OP_FILL    = 3'd3;
  localparam logic [2:0]      OP_INV     = 3'd4;
  localparam logic [4:0]      INV_OP_MAX = 5'd6;
  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(TLBNUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SFETCH, S_SWAIT, S_READ, S_WRITE, S_INV, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [IDXW-1:0]   fill_cnt;
  logic [IDXW-1:0]   lat_index;
  logic [9:0]        lat_asid;
  logic [18:0]       lat_vppn;
  logic              lat_odd;
  logic [4:0]        lat_inv_op;
  logic [88:0]       lat_wentry;

  assign accept = req_valid && req_ready;
  assign busy   = (state_q != S_IDLE);

  // TLB-side payloads come straight from the latched request; only the
  // strobes qualify them.
  assign tlb_s1_vppn     = lat_vppn;
  assign tlb_s1_odd_page = lat_odd;
  assign tlb_s1_asid     = lat_asid;
  assign tlb_r_index     = lat_index;
  // The response index already holds the write target (request index or fill slot).
  assign tlb_w_index     = rsp_index;
  assign tlb_w_entry     = lat_wentry;
  assign tlb_inv_op      = lat_inv_op;
  assign tlb_inv_asid    = lat_asid;
  assign tlb_inv_vpn     = lat_vppn;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and the one-cycle TLB strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d      = state_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    tlb_s1_fetch = 1'b0;
    tlb_we       = 1'b0;
    tlb_inv_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_SRCH:       state_d = S_SFETCH;
            OP_RD:         state_d = S_READ;
            OP_WR, OP_FILL: state_d = S_WRITE;
            OP_INV:        state_d = S_INV;
            default:       state_d = S_RESP;
          endcase
        end
      end
      S_SFETCH: begin
        tlb_s1_fetch = 1'b1;
        state_d      = S_SWAIT;
      end
      S_SWAIT: state_d = S_RESP;
      S_READ:  state_d = S_RESP;
      S_WRITE: begin
        tlb_we  = 1'b1;
        state_d = S_RESP;
      end
      S_INV: begin
        tlb_inv_en = (lat_inv_op <= INV_OP_MAX);
        state_d    = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request payload capture at accept.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; nothing observes them until an
    // accept has overwritten them, and every strobe that uses them is gated.
    if (accept) begin
      lat_index  <= req_index;
      lat_asid   <= req_asid;
      lat_vppn   <= req_vppn;
      lat_odd    <= req_odd;
      lat_inv_op <= req_inv_op;
      lat_wentry <= req_wentry;
    end
  end

  // Response fields: initialised at accept, filled in by SWAIT / READ.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_op     <= '0;
      rsp_found  <= 1'b0;
      rsp_index  <= '0;
      rsp_rentry <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rsp_op     <= req_op;
            rsp_found  <= 1'b0;
            rsp_rentry <= '0;
            case (req_op)
              OP_RD, OP_WR: rsp_index <= req_index;
              OP_FILL:      rsp_index <= fill_cnt;
              default:      rsp_index <= '0;
            endcase
          end
        end
        S_SWAIT: begin
          rsp_found <= tlb_s1_found;
          rsp_index <= tlb_s1_index;
        end
        S_READ: begin
          rsp_found  <= 1'b1;
          rsp_rentry <= tlb_r_entry;
        end
        default: ;
      endcase
    end
  end

  // Free-running fill slot pointer, wrapping at the last entry.
  always_ff @(posedge clk) begin
    if (!resetn)                  fill_cnt <= '0;
    else if (fill_cnt == LAST_IDX) fill_cnt <= '0;
    else                           fill_cnt <= fill_cnt + 1'b1;
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed bench for tlb_op_ctrl with a small TLB model
// (two entries, one-cycle search, combinational read).
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 2;
  localparam int IDXW   = 1;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  // entry = {vppn, asid, g, ps, e, page0, page1}
  localparam logic [88:0] E0 = {19'h00001, 10'h000, 1'b0, 6'd12, 1'b1, 26'h0001111, 26'h0002222};
  localparam logic [88:0] E1 = {19'h12345, 10'h005, 1'b0, 6'd12, 1'b1, 26'h0ABCDEF, 26'h1234567};
  localparam logic [88:0] WR_ENTRY = {1'b1, 88'h2345_6789_ABCD_EF01_2345_67};
  localparam logic [88:0] F1 = {19'h0AAAA, 10'h011, 1'b1, 6'd12, 1'b1, 26'h1555555, 26'h2AAAAAA};
  localparam logic [88:0] F2 = {19'h05555, 10'h022, 1'b0, 6'd21, 1'b1, 26'h0F0F0F0, 26'h30F0F0F};

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            req_valid, req_ready;
  logic [2:0]      req_op;
  logic [IDXW-1:0] req_index;
  logic [9:0]      req_asid;
  logic [18:0]     req_vppn;
  logic            req_odd;
  logic [4:0]      req_inv_op;
  logic [88:0]     req_wentry;
  logic            rsp_valid, rsp_ready;
  logic [2:0]      rsp_op;
  logic            rsp_found;
  logic [IDXW-1:0] rsp_index;
  logic [88:0]     rsp_rentry;
  logic            tlb_s1_fetch;
  logic [18:0]     tlb_s1_vppn;
  logic            tlb_s1_odd_page;
  logic [9:0]      tlb_s1_asid;
  logic            tlb_s1_found;
  logic [IDXW-1:0] tlb_s1_index;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic [88:0]     tlb_w_entry;
  logic [IDXW-1:0] tlb_r_index;
  logic [88:0]     tlb_r_entry;
  logic            tlb_inv_en;
  logic [4:0]      tlb_inv_op;
  logic [9:0]      tlb_inv_asid;
  logic [18:0]     tlb_inv_vpn;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int inv_cnt = 0;
  int fetch_cnt = 0;

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_asid(req_asid), .req_vppn(req_vppn),
    .req_odd(req_odd), .req_inv_op(req_inv_op), .req_wentry(req_wentry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_found(rsp_found), .rsp_index(rsp_index), .rsp_rentry(rsp_rentry),
    .tlb_s1_fetch(tlb_s1_fetch), .tlb_s1_vppn(tlb_s1_vppn),
    .tlb_s1_odd_page(tlb_s1_odd_page), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_inv_en(tlb_inv_en), .tlb_inv_op(tlb_inv_op),
    .tlb_inv_asid(tlb_inv_asid), .tlb_inv_vpn(tlb_inv_vpn),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // TLB model and expected fill pointer
  logic [88:0]     tlb_mem [TLBNUM];
  logic [IDXW-1:0] model_cnt;

  function automatic logic hit(input logic [88:0] e, input logic [18:0] vppn,
                               input logic [9:0] asid);
    return e[52] && (e[88:70] == vppn) && (e[59] || (e[69:60] == asid));
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      tlb_mem[0]   <= E0;
      tlb_mem[1]   <= E1;
      tlb_s1_found <= 1'b0;
      tlb_s1_index <= '0;
      model_cnt    <= '0;
    end else begin
      if (tlb_we) tlb_mem[tlb_w_index] <= tlb_w_entry;
      if (tlb_s1_fetch) begin
        tlb_s1_found <= hit(tlb_mem[0], tlb_s1_vppn, tlb_s1_asid) ||
                        hit(tlb_mem[1], tlb_s1_vppn, tlb_s1_asid);
        tlb_s1_index <= hit(tlb_mem[1], tlb_s1_vppn, tlb_s1_asid) ? 1'b1 : 1'b0;
      end
      model_cnt <= (model_cnt == IDXW'(TLBNUM - 1)) ? '0 : model_cnt + 1'b1;
    end
  end

  assign tlb_r_entry = tlb_mem[tlb_r_index];

  always @(posedge clk) begin
    if (tlb_we)       we_cnt    <= we_cnt + 1;
    if (tlb_inv_en)   inv_cnt   <= inv_cnt + 1;
    if (tlb_s1_fetch) fetch_cnt <= fetch_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [88:0] got, input logic [88:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request in an IDLE cycle; returns in cycle T+1.
  task automatic send(input logic [2:0] op, input logic [IDXW-1:0] idx,
                      input logic [9:0] asid, input logic [18:0] vppn,
                      input logic [4:0] inv_op, input logic [88:0] went);
    req_op     = op;
    req_index  = idx;
    req_asid   = asid;
    req_vppn   = vppn;
    req_odd    = 1'b0;
    req_inv_op = inv_op;
    req_wentry = went;
    req_valid  = 1'b1;
    check("req_ready_at_accept", req_ready, 1'b1);
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("back_to_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int snap;
    logic [IDXW-1:0] fidx1;
    req_valid = 1'b0; req_op = '0; req_index = '0; req_asid = '0; req_vppn = '0;
    req_odd = 1'b0; req_inv_op = '0; req_wentry = '0; rsp_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_strobes", {tlb_s1_fetch, tlb_we, tlb_inv_en}, 3'b000);
    check("rst_rsp_fields", {rsp_op, rsp_found, rsp_index}, '0);
    check("rst_rsp_rentry", rsp_rentry, '0);
    resetn = 1'b1;
    tick();

    // search hit at index 1
    snap = fetch_cnt;
    send(OP_SRCH, 1'b0, 10'h005, 19'h12345, 5'd0, '0);
    check("srch_fetch_t1", tlb_s1_fetch, 1'b1);
    check("srch_vppn", tlb_s1_vppn, 19'h12345);
    check("srch_asid", tlb_s1_asid, 10'h005);
    check("srch_busy", busy, 1'b1);
    check("srch_no_rsp_t1", rsp_valid, 1'b0);
    tick();
    check("srch_fetch_t2", tlb_s1_fetch, 1'b0);
    check("srch_no_rsp_t2", rsp_valid, 1'b0);
    tick();
    check("srch_rsp_t3", rsp_valid, 1'b1);
    check("srch_found", rsp_found, 1'b1);
    check("srch_index", rsp_index, 1'b1);
    check("srch_op", rsp_op, OP_SRCH);
    check("srch_fetch_count", fetch_cnt - snap, 1);
    finish_rsp();

    // search miss: asid differs and entry is not global
    send(OP_SRCH, 1'b1, 10'h006, 19'h12345, 5'd0, '0);
    tick(); tick();
    check("miss_rsp_valid", rsp_valid, 1'b1);
    check("miss_found", rsp_found, 1'b0);
    check("miss_index", rsp_index, 1'b0);
    finish_rsp();

    // write index 1, then read it back
    snap = we_cnt;
    send(OP_WR, 1'b1, '0, '0, 5'd0, WR_ENTRY);
    check("wr_we_t1", tlb_we, 1'b1);
    check("wr_w_index", tlb_w_index, 1'b1);
    check("wr_w_entry", tlb_w_entry, WR_ENTRY);
    check("wr_other_strobes", {tlb_s1_fetch, tlb_inv_en}, 2'b00);
    tick();
    check("wr_we_t2", tlb_we, 1'b0);
    check("wr_rsp_t2", rsp_valid, 1'b1);
    check("wr_rsp_index", rsp_index, 1'b1);
    check("wr_rsp_found_entry", {rsp_found, rsp_rentry}, '0);
    check("wr_rsp_op", rsp_op, OP_WR);
    check("wr_we_count", we_cnt - snap, 1);
    finish_rsp();

    send(OP_RD, 1'b1, '0, '0, 5'd0, '0);
    check("rd_r_index", tlb_r_index, 1'b1);
    check("rd_no_rsp_t1", rsp_valid, 1'b0);
    tick();
    check("rd_rsp_t2", rsp_valid, 1'b1);
    check("rd_rentry", rsp_rentry, WR_ENTRY);
    check("rd_found", rsp_found, 1'b1);
    check("rd_index", rsp_index, 1'b1);
    check("rd_op", rsp_op, OP_RD);
    finish_rsp();

    // two fills accepted 3 cycles apart: slot 1 then wrapped slot 0
    if (model_cnt != 1'b1) tick();
    send(OP_FILL, 1'b0, '0, '0, 5'd0, F1);
    check("fill1_we", tlb_we, 1'b1);
    check("fill1_w_index", tlb_w_index, 1'b1);
    check("fill1_w_entry", tlb_w_entry, F1);
    fidx1 = tlb_w_index;
    tick();
    check("fill1_rsp_index", rsp_index, 1'b1);
    check("fill1_rsp_op", rsp_op, OP_FILL);
    finish_rsp();
    send(OP_FILL, 1'b1, '0, '0, 5'd0, F2);
    check("fill2_w_index_wrap", tlb_w_index, 1'b0);
    check("fill2_w_entry", tlb_w_entry, F2);
    check("fill_index_differs", tlb_w_index != fidx1, 1'b1);
    tick();
    check("fill2_rsp_valid", rsp_valid, 1'b1);
    check("fill2_rsp_index", rsp_index, 1'b0);
    finish_rsp();

    // invalidate op 4 pulses once; op 9 does not pulse
    snap = inv_cnt;
    send(OP_INV, 1'b0, 10'h003, 19'h00ABC, 5'd4, '0);
    check("inv4_en_t1", tlb_inv_en, 1'b1);
    check("inv4_fields", {tlb_inv_op, tlb_inv_asid, tlb_inv_vpn}, {5'd4, 10'h003, 19'h00ABC});
    check("inv4_no_we", tlb_we, 1'b0);
    tick();
    check("inv4_en_t2", tlb_inv_en, 1'b0);
    check("inv4_rsp_t2", rsp_valid, 1'b1);
    check("inv4_rsp_found", rsp_found, 1'b0);
    check("inv4_rsp_op", rsp_op, OP_INV);
    finish_rsp();
    check("inv4_pulse_count", inv_cnt - snap, 1);

    snap = inv_cnt;
    send(OP_INV, 1'b0, 10'h003, 19'h00ABC, 5'd9, '0);
    check("inv9_en_t1", tlb_inv_en, 1'b0);
    check("inv9_busy", busy, 1'b1);
    tick();
    check("inv9_rsp_t2", rsp_valid, 1'b1);
    finish_rsp();
    check("inv9_pulse_count", inv_cnt - snap, 0);

    // response held for 5 cycles with a competing request pending
    snap = we_cnt;
    send(OP_WR, 1'b0, '0, '0, 5'd0, F1);
    tick();
    req_op    = OP_RD;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", rsp_valid, 1'b1);
      check("stall_rsp_fields", {rsp_op, rsp_found, rsp_index}, {OP_WR, 1'b0, 1'b0});
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_busy", busy, 1'b1);
      check("stall_we", tlb_we, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    check("stall_rsp_still_valid", rsp_valid, 1'b1);
    finish_rsp();
    check("stall_we_count", we_cnt - snap, 1);

    // reset during SFETCH drops the search
    snap = fetch_cnt;
    send(OP_SRCH, 1'b0, 10'h005, 19'h12345, 5'd0, '0);
    check("rstmid_fetch", tlb_s1_fetch, 1'b1);
    resetn = 1'b0;
    tick();
    check("rstmid_idle", busy, 1'b0);
    check("rstmid_fetch_off", tlb_s1_fetch, 1'b0);
    check("rstmid_no_rsp", rsp_valid, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_quiet", {rsp_valid, tlb_s1_fetch, busy}, 3'b000);
    end
    check("rstmid_fetch_count", fetch_cnt - snap, 1);

    // read leaves rentry non-zero, then illegal op 6 must clear it
    send(OP_RD, 1'b1, '0, '0, 5'd0, '0);
    tick();
    check("rd2_rentry", rsp_rentry, E1);
    finish_rsp();
    snap = we_cnt + inv_cnt + fetch_cnt;
    send(3'd6, 1'b1, 10'h3FF, 19'h7FFFF, 5'd2, F2);
    check("ill_rsp_t1", rsp_valid, 1'b1);
    check("ill_found_index", {rsp_found, rsp_index}, 2'b00);
    check("ill_rentry", rsp_rentry, '0);
    check("ill_op", rsp_op, 3'd6);
    check("ill_strobes", {tlb_s1_fetch, tlb_we, tlb_inv_en}, 3'b000);
    finish_rsp();
    check("ill_strobe_count", we_cnt + inv_cnt + fetch_cnt - snap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
